// File: rtl/montgomery_mult_param.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M with the
// final conditional subtraction, valid/ready operand and result handshakes.
module montgomery_mult_param #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             square,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOOP = 2'd1;
  localparam logic [1:0] SUB  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   c_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] u;
  logic [WIDTH+1:0] d;
  logic             last_iter;

  // A is shifted right each iteration so bit i of the original operand is always at a_sh[0].
  always_comb begin
    t = {1'b0, c_reg} + (a_sh[0] ? {2'b00, b_reg} : '0);
    u = t + (t[0] ? {2'b00, m_reg} : '0);
    d = {1'b0, c_reg} - {2'b00, m_reg};
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      error     <= 1'b0;
      cnt       <= '0;
      c_reg     <= '0;
      a_sh      <= '0;
      b_reg     <= '0;
      m_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_reg <= square ? in_a : in_b;
            m_reg <= in_m;
            c_reg <= '0;
            cnt   <= '0;
            if (!in_m[0]) begin
              result    <= '0;
              error     <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= LOOP;
            end
          end
        end
        LOOP: begin
          c_reg <= u[WIDTH+1:1];
          a_sh  <= a_sh >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) state <= SUB;
        end
        SUB: begin
          result    <= d[WIDTH+1] ? c_reg[WIDTH-1:0] : d[WIDTH-1:0];
          error     <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Self-checking bench for montgomery_mult_param: directed and random checks at
// WIDTH=8 and WIDTH=1024 against a modular-arithmetic reference model.
module tb_montgomery_mult_param;

  localparam int SW = 8;
  localparam int WW = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          s_in_valid = 1'b0, s_in_ready, s_square = 1'b0;
  logic [SW-1:0] s_in_a = '0, s_in_b = '0, s_in_m = '0, s_result;
  logic          s_out_valid, s_out_ready = 1'b1, s_error, s_busy;

  logic          w_in_valid = 1'b0, w_in_ready, w_square = 1'b0;
  logic [WW-1:0] w_in_a = '0, w_in_b = '0, w_in_m = '0, w_result;
  logic          w_out_valid, w_out_ready = 1'b1, w_error, w_busy;

  int checks = 0;
  int errors = 0;

  montgomery_mult_param #(.WIDTH(SW)) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .square(s_square), .in_a(s_in_a), .in_b(s_in_b), .in_m(s_in_m),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
    .error(s_error), .busy(s_busy)
  );

  montgomery_mult_param #(.WIDTH(WW)) dut_w (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .square(w_square), .in_a(w_in_a), .in_b(w_in_b), .in_m(w_in_m),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
    .error(w_error), .busy(w_busy)
  );

  // (a*b mod m) multiplied by 2^-w mod m, via w modular halvings.
  function automatic logic [WW-1:0] mont_ref(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                              input logic [WW-1:0] m, input int unsigned w);
    logic [2*WW+1:0] p;
    logic [2*WW+1:0] mm;
    mm = {{(WW+2){1'b0}}, m};
    p  = ({{(WW+2){1'b0}}, a} * {{(WW+2){1'b0}}, b}) % mm;
    for (int unsigned i = 0; i < w; i++)
      p = p[0] ? (p + mm) >> 1 : p >> 1;
    return p[WW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation on the 8-bit instance; cyc counts sample points from the
  // accept edge to the first one with out_valid high (-1 on timeout).
  task automatic op8(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic [SW-1:0] m,
                     input logic sq, output int cyc, output logic [SW-1:0] res, output logic err);
    int k;
    k = 0;
    while (!s_in_ready && k < 50) begin tick(); k++; end
    s_in_a = a; s_in_b = b; s_in_m = m; s_square = sq; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    cyc = 1;
    while (!s_out_valid && cyc < 100) begin tick(); cyc++; end
    if (!s_out_valid) cyc = -1;
    res = s_result;
    err = s_error;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({s_in_ready, s_out_valid, s_busy, s_error} !== 4'b1000 || s_result !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: ready/valid/busy/err=%b result=%0d, required 1000 result=0",
               {s_in_ready, s_out_valid, s_busy, s_error}, s_result);
    end
  endtask

  task automatic test_basic();
    int cyc; logic [SW-1:0] res; logic err;
    op8(8'd5, 8'd7, 8'd13, 1'b0, cyc, res, err);
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL basic_latency: got %0d required 10", cyc); end
    checks++;
    if (res !== 8'd1 || err !== 1'b0) begin
      errors++; $display("FAIL basic_result: got %0d err=%b required 1 err=0", res, err);
    end
    tick();
    checks++;
    if (s_in_ready !== 1'b1 || s_result !== 8'd1) begin
      errors++; $display("FAIL idle_hold: ready=%b result=%0d required ready=1 result=1", s_in_ready, s_result);
    end
  endtask

  task automatic test_square();
    int cyc; logic [SW-1:0] res; logic err;
    op8(8'd5, 8'd99, 8'd13, 1'b1, cyc, res, err);
    checks++;
    if (res !== 8'd10 || cyc !== 10) begin
      errors++; $display("FAIL square: got %0d cyc=%0d required 10 cyc=10", res, cyc);
    end
  endtask

  task automatic test_subtract();
    int cyc; logic [SW-1:0] res; logic err;
    op8(8'd12, 8'd12, 8'd13, 1'b0, cyc, res, err);
    checks++;
    if (res !== 8'd3) begin errors++; $display("FAIL sub_m13: got %0d required 3", res); end
    op8(8'd254, 8'd254, 8'd255, 1'b0, cyc, res, err);
    checks++;
    if (res !== 8'd1 || err !== 1'b0) begin
      errors++; $display("FAIL sub_m255: got %0d err=%b required 1 err=0", res, err);
    end
  endtask

  task automatic test_even_modulus();
    int cyc; logic [SW-1:0] res; logic err;
    op8(8'd3, 8'd4, 8'd12, 1'b0, cyc, res, err);
    checks++;
    if (cyc !== 1 || res !== 8'd0 || err !== 1'b1) begin
      errors++; $display("FAIL even_mod: cyc=%0d result=%0d err=%b required cyc=1 result=0 err=1", cyc, res, err);
    end
    op8(8'd5, 8'd7, 8'd13, 1'b0, cyc, res, err);
    checks++;
    if (res !== 8'd1 || err !== 1'b0 || cyc !== 10) begin
      errors++; $display("FAIL after_even: result=%0d err=%b cyc=%0d required 1 0 10", res, err, cyc);
    end
  endtask

  task automatic test_backpressure();
    int cyc; logic [SW-1:0] res; logic err;
    s_out_ready = 1'b0;
    op8(8'd5, 8'd7, 8'd13, 1'b0, cyc, res, err);
    checks++;
    if (res !== 8'd1) begin errors++; $display("FAIL bp_result: got %0d required 1", res); end
    for (int i = 0; i < 20; i++) begin
      s_in_valid = i[0];
      s_in_a = 8'd2; s_in_b = 8'd3; s_in_m = 8'd11;
      tick();
      checks++;
      if (s_out_valid !== 1'b1 || s_result !== 8'd1 || s_in_ready !== 1'b0 || s_busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%0d ready=%b busy=%b required 1 1 0 1",
                 i, s_out_valid, s_result, s_in_ready, s_busy);
      end
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    tick();
    checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: ready=%b valid=%b required 1 0", s_in_ready, s_out_valid);
    end
    op8(8'd12, 8'd12, 8'd13, 1'b0, cyc, res, err);
    checks++;
    if (res !== 8'd3 || cyc !== 10) begin
      errors++; $display("FAIL back_to_back: got %0d cyc=%0d required 3 cyc=10", res, cyc);
    end
    // Throughput with out_ready held: next accept lands WIDTH+3 edges after the previous one.
    tick();
    checks++;
    if (s_in_ready !== 1'b1) begin errors++; $display("FAIL throughput_ready: got %b required 1", s_in_ready); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [SW-1:0] res; logic err; bit seen;
    s_in_a = 8'd9; s_in_b = 8'd4; s_in_m = 8'd13; s_square = 1'b0; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({s_in_ready, s_out_valid, s_busy} !== 3'b100 || s_result !== 8'd0) begin
      errors++; $display("FAIL reset_mid: ready/valid/busy=%b result=%0d required 100 result=0",
                         {s_in_ready, s_out_valid, s_busy}, s_result);
    end
    seen = 1'b0;
    for (int i = 0; i < SW + 5; i++) begin tick(); if (s_out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_discard: out_valid seen=%b required 0", seen); end
    op8(8'd5, 8'd7, 8'd13, 1'b0, cyc, res, err);
    checks++;
    if (res !== 8'd1 || cyc !== 10) begin
      errors++; $display("FAIL after_reset: got %0d cyc=%0d required 1 cyc=10", res, cyc);
    end
  endtask

  task automatic test_random8();
    int cyc; logic [SW-1:0] res, a, b, m, exp; logic err, sq;
    for (int n = 0; n < 12; n++) begin
      m  = SW'($urandom_range(3, 255) | 1);
      a  = SW'($urandom % m);
      b  = SW'($urandom % m);
      sq = 1'($urandom);
      exp = SW'(mont_ref(WW'(a), sq ? WW'(a) : WW'(b), WW'(m), SW));
      op8(a, b, m, sq, cyc, res, err);
      checks++;
      if (res !== exp || err !== 1'b0 || cyc !== SW + 2) begin
        errors++; $display("FAIL rand8[%0d]: a=%0d b=%0d m=%0d sq=%b got %0d cyc=%0d required %0d cyc=%0d",
                           n, a, b, m, sq, res, cyc, exp, SW + 2);
      end
    end
  endtask

  task automatic test_wide();
    logic [WW-1:0] a, b, m, exp, res;
    int cyc;
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < WW / 32; j++) m[j*32 +: 32] = $urandom;
      m[0] = 1'b1;
      if (n == 0) m = WW'(13);
      for (int j = 0; j < WW / 32; j++) a[j*32 +: 32] = $urandom;
      for (int j = 0; j < WW / 32; j++) b[j*32 +: 32] = $urandom;
      a = a % m;
      b = b % m;
      if (n == 0) begin a = WW'(5); b = WW'(7); end
      exp = mont_ref(a, b, m, WW);
      w_in_a = a; w_in_b = b; w_in_m = m; w_square = 1'b0; w_in_valid = 1'b1;
      tick();
      w_in_valid = 1'b0;
      cyc = 1;
      while (!w_out_valid && cyc < WW + 20) begin tick(); cyc++; end
      if (!w_out_valid) cyc = -1;
      res = w_result;
      checks++;
      if (res !== exp || w_error !== 1'b0 || cyc !== WW + 2) begin
        errors++; $display("FAIL wide[%0d]: cyc=%0d err=%b low word got %h required %h cyc=%0d",
                           n, cyc, w_error, res[63:0], exp[63:0], WW + 2);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_square();
    test_subtract();
    test_even_modulus();
    test_backpressure();
    test_reset_mid();
    test_random8();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
